hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the vector processor front end. It drives the PC, IF/ID and ID/EXE register controls: load-use stalls, taken-branch squashes, multi-cycle vector ops held in EXE, global freeze on data-memory wait, and a terminal halt. It sits beside the ID/EXE pipeline register and consumes decode (ID) and execute (EXE) stage fields.

## Interface

- No parameters.
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- id_rs_addr  input  5  rs of instruction in ID
- id_rt_addr  input  5  rt of instruction in ID
- id_uses_rt  input  1  ID instruction reads rt as a source
- id_vec_op  input  1  ID instruction is a vector op
- id_vec_len  input  4  element count of ID vector op
- id_halt  input  1  ID instruction is HALT
- exe_rt_addr  input  5  load destination of instruction in EXE
- exe_memtoreg  input  1  EXE instruction is a load
- exe_branch_taken  input  1  EXE branch resolved taken
- mem_busy  input  1  data memory not ready
- pc_en  output  1  PC update enable
- ifid_en  output  1  IF/ID load enable
- ifid_flush  output  1  IF/ID load NOP
- idexe_bubble  output  1  ID/EXE load NOP (all control fields 0)
- idexe_hold  output  1  ID/EXE keep current contents
- elem_idx  output  4  vector element executing in EXE
- state  output  2  FSM state
- halted  output  1  core halted
- stall_cycles  output  16  stall counter (see Configuration)

## Operation

- States: RUN=2'd0, VEC=2'd1, HALT=2'd2; 2'd3 is illegal and returns to RUN next cycle with RUN outputs.
- Load-use hazard (lu): exe_memtoreg && exe_rt_addr!=0 && (exe_rt_addr==id_rs_addr || (id_uses_rt && exe_rt_addr==id_rt_addr)).
- Priority, highest first: reset, mem_busy, state VEC/HALT, exe_branch_taken, lu, id_halt, id_vec_op.
- mem_busy (any state): pc_en=0, ifid_en=0, idexe_hold=1, flush/bubble=0; state, counters and elem_idx frozen.
- RUN, default: pc_en=1, ifid_en=1, all others 0.
- RUN, branch taken: pc_en=1, ifid_flush=1, idexe_bubble=1; lu, halt and vec ignored.
- RUN, lu: pc_en=0, ifid_en=0, idexe_bubble=1 for one cycle; the load advances, lu clears.
- RUN, id_halt: pc_en=0, ifid_en=0, idexe_bubble=1; next state HALT.
- RUN, id_vec_op with id_vec_len>=2: default outputs (op enters EXE); vcnt<=id_vec_len-1; next state VEC. id_vec_len 0 or 1: single-cycle op, stays RUN.
- VEC: pc_en=0, ifid_en=0, idexe_hold=1; vcnt decrements; when vcnt==1, next state RUN.
- HALT: pc_en=0, ifid_en=0, idexe_bubble=1, halted=1 until reset.
- elem_idx next value: elem_idx+1 in VEC, else 0. An N-element op therefore sees elem_idx 0..N-1 over its N EXE cycles, the last in RUN.
- All control outputs are combinational from state, counters and inputs. state, vcnt, elem_idx and stall_cycles are registered.

## Timing

- Reset (rst_n=0 at edge): state=RUN, vcnt=0, elem_idx=0, stall_cycles=0. While rst_n=0, outputs are forced to pc_en=0, ifid_en=0, ifid_flush=0, idexe_bubble=1, idexe_hold=0, halted=0.
- Reset during VEC or HALT aborts to RUN at that edge.
- Load-use costs exactly 1 bubble. A taken branch costs 1 squashed slot. An N-element vector op occupies EXE for N cycles (N-1 hold cycles).
- A branch with mem_busy is deferred until mem_busy drops; EXE is frozen, so exe_branch_taken stays stable.

## Configuration

- HAZARD_PERF_CNT_EN defined: stall_cycles is a 16-bit saturating counter (sticks at 16'hFFFF). It increments each cycle with rst_n=1, pc_en=0 and state!=HALT.
- Undefined: stall_cycles tied to 16'd0 and no counter flops are built.

## Test plan

- Load r5 in EXE, ID reads rs=5 -> one cycle of pc_en=0, ifid_en=0, idexe_bubble=1, then normal flow; with rt=5 and id_uses_rt=0 -> no stall.
- Load to r0 hazard -> no stall. Taken branch simultaneous with lu -> ifid_flush=1, idexe_bubble=1, pc_en=1.
- Vector op id_vec_len=4 -> state VEC for 3 cycles with idexe_hold=1, elem_idx 0,1,2,3 across 4 EXE cycles, then RUN; id_vec_len=1 -> no VEC entry.
- mem_busy held 3 cycles mid-VEC (elem_idx=1) -> all frozen 3 cycles, elem_idx stays 1, then resumes at 2.
- id_halt -> halted=1 and state=2 persist 10 cycles; rst_n=0 for one edge -> state=0, halted=0.
- With HAZARD_PERF_CNT_EN: 1 load-use + 4-element vec + 2 mem_busy cycles -> stall_cycles=6. Without the macro -> stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch squash, multi-cycle vector hold,
// memory-wait freeze and halt. Define HAZARD_PERF_CNT_EN to build the stall-cycle counter.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_uses_rt,
    input  logic        id_vec_op,
    input  logic [3:0]  id_vec_len,
    input  logic        id_halt,
    input  logic [4:0]  exe_rt_addr,
    input  logic        exe_memtoreg,
    input  logic        exe_branch_taken,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idexe_bubble,
    output logic        idexe_hold,
    output logic [3:0]  elem_idx,
    output logic [1:0]  state,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        VEC  = 2'd1,
        HALT = 2'd2,
        ILL  = 2'd3
    } state_t;

    state_t     cur, nxt;
    logic [3:0] vcnt, vcnt_nxt, elem_nxt;
    logic       lu;

    assign lu = exe_memtoreg && (exe_rt_addr != 5'd0) &&
                ((exe_rt_addr == id_rs_addr) || (id_uses_rt && (exe_rt_addr == id_rt_addr)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur      <= RUN;
            vcnt     <= 4'd0;
            elem_idx <= 4'd0;
        end else begin
            cur      <= nxt;
            vcnt     <= vcnt_nxt;
            elem_idx <= elem_nxt;
        end
    end

    always_comb begin
        nxt          = cur;
        vcnt_nxt     = vcnt;
        elem_nxt     = elem_idx;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idexe_bubble = 1'b0;
        idexe_hold   = 1'b0;
        halted       = 1'b0;
        if (!rst_n) begin
            idexe_bubble = 1'b1;
        end else if (mem_busy) begin
            // EXE is frozen: everything holds, including a pending branch
            idexe_hold = 1'b1;
            halted     = (cur == HALT);
        end else begin
            case (cur)
                RUN: begin
                    elem_nxt = 4'd0;
                    if (exe_branch_taken) begin
                        pc_en        = 1'b1;
                        ifid_flush   = 1'b1;
                        idexe_bubble = 1'b1;
                    end else if (lu) begin
                        idexe_bubble = 1'b1;
                    end else if (id_halt) begin
                        idexe_bubble = 1'b1;
                        nxt          = HALT;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                        if (id_vec_op && (id_vec_len >= 4'd2)) begin
                            vcnt_nxt = id_vec_len - 4'd1;
                            nxt      = VEC;
                        end
                    end
                end
                VEC: begin
                    idexe_hold = 1'b1;
                    elem_nxt   = elem_idx + 4'd1;
                    vcnt_nxt   = vcnt - 4'd1;
                    // <=1 rather than ==1 so a corrupted zero count cannot wrap
                    if (vcnt <= 4'd1) begin
                        nxt      = RUN;
                        vcnt_nxt = 4'd0;
                    end
                end
                HALT: begin
                    idexe_bubble = 1'b1;
                    halted       = 1'b1;
                    elem_nxt     = 4'd0;
                end
                default: begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    nxt      = RUN;
                    vcnt_nxt = 4'd0;
                    elem_nxt = 4'd0;
                end
            endcase
        end
    end

    assign state = cur;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_q <= 16'd0;
        else if (!pc_en && (cur != HALT) && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a rule-level behavioural model.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs_addr, id_rt_addr, exe_rt_addr;
    logic        id_uses_rt, id_vec_op, id_halt, exe_memtoreg, exe_branch_taken, mem_busy;
    logic [3:0]  id_vec_len;
    logic        pc_en, ifid_en, ifid_flush, idexe_bubble, idexe_hold, halted;
    logic [3:0]  elem_idx;
    logic [1:0]  state;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
        .id_vec_op(id_vec_op), .id_vec_len(id_vec_len), .id_halt(id_halt),
        .exe_rt_addr(exe_rt_addr), .exe_memtoreg(exe_memtoreg),
        .exe_branch_taken(exe_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idexe_bubble(idexe_bubble), .idexe_hold(idexe_hold), .elem_idx(elem_idx),
        .state(state), .halted(halted), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Model: halt flag, number of hold cycles left for the vector op in EXE, element, stall count
    bit m_halt      = 1'b0;
    int m_vec_left  = 0;
    int m_elem      = 0;
    int m_stall     = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit m_lu();
        return exe_memtoreg && exe_rt_addr != 0 &&
               (exe_rt_addr == id_rs_addr || (id_uses_rt && exe_rt_addr == id_rt_addr));
    endfunction

    // {pc_en, ifid_en, ifid_flush, idexe_bubble, idexe_hold, halted}
    function automatic logic [5:0] m_ctl();
        if (!rst_n)            return 6'b000100;
        if (mem_busy)          return {5'b00001, m_halt};
        if (m_halt)            return 6'b000101;
        if (m_vec_left > 0)    return 6'b000010;
        if (exe_branch_taken)  return 6'b101100;
        if (m_lu() || id_halt) return 6'b000100;
        return 6'b110000;
    endfunction

    function automatic int m_state();
        return m_halt ? 2 : (m_vec_left > 0 ? 1 : 0);
    endfunction

    function automatic int m_stall_out();
`ifdef HAZARD_PERF_CNT_EN
        return m_stall;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) begin
        logic [5:0] c;
        c = m_ctl();
        if (!rst_n) begin
            m_halt = 0; m_vec_left = 0; m_elem = 0; m_stall = 0;
        end else begin
            if (!c[5] && !m_halt && m_stall < 65535) m_stall++;
            if (!mem_busy && !m_halt) begin
                if (m_vec_left > 0) begin
                    m_elem++;
                    m_vec_left--;
                end else begin
                    m_elem = 0;
                    if (!exe_branch_taken && !m_lu()) begin
                        if (id_halt) m_halt = 1;
                        else if (id_vec_op && id_vec_len >= 2) m_vec_left = id_vec_len - 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] c;
        c = m_ctl();
        chk("pc_en",        pc_en,        c[5]);
        chk("ifid_en",      ifid_en,      c[4]);
        chk("ifid_flush",   ifid_flush,   c[3]);
        chk("idexe_bubble", idexe_bubble, c[2]);
        chk("idexe_hold",   idexe_hold,   c[1]);
        chk("halted",       halted,       c[0]);
        chk("state",        state,        m_state());
        chk("elem_idx",     elem_idx,     m_elem);
        chk("stall_cycles", stall_cycles, m_stall_out());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs_addr = 5'd1; id_rt_addr = 5'd2; id_uses_rt = 1'b0;
        id_vec_op = 1'b0; id_vec_len = 4'd0; id_halt = 1'b0;
        exe_rt_addr = 5'd0; exe_memtoreg = 1'b0; exe_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_bubble", idexe_bubble, 1);
        chk("rst_pc_en", pc_en, 0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        chk("reset_state", state, 0);
        chk("reset_elem", elem_idx, 0);
        do_reset();
        #1 chk("idle_pc_en", pc_en, 1);
        tick();

        // Load to r5 in EXE, ID reads rs=5: one bubble, then normal flow
        exe_memtoreg = 1; exe_rt_addr = 5'd5; id_rs_addr = 5'd5;
        #1 chk("lu_pc_en", pc_en, 0);
        chk("lu_bubble", idexe_bubble, 1);
        tick();
        idle();
        #1 chk("lu_after_pc_en", pc_en, 1);
        tick();
        // rt=5 but rt not a source -> no stall
        exe_memtoreg = 1; exe_rt_addr = 5'd5; id_rt_addr = 5'd5; id_uses_rt = 0;
        #1 chk("rt_unused_pc_en", pc_en, 1);
        tick();
        // load to r0 never stalls
        exe_rt_addr = 5'd0; id_rs_addr = 5'd0;
        #1 chk("r0_pc_en", pc_en, 1);
        tick();
        // branch taken together with lu: squash wins
        exe_rt_addr = 5'd7; id_rs_addr = 5'd7; exe_branch_taken = 1;
        #1 chk("br_lu_flush", ifid_flush, 1);
        chk("br_lu_pc_en", pc_en, 1);
        tick();
        idle();

        // 4-element vector op
        id_vec_op = 1; id_vec_len = 4'd4;
        #1 chk("vec_issue_state", state, 0);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            #1 chk("vec_elem", elem_idx, k);
            chk("vec_state", state, (k < 3) ? 1 : 0);
            chk("vec_hold", idexe_hold, (k < 3) ? 1 : 0);
            tick();
        end
        // single-element op stays in RUN
        id_vec_op = 1; id_vec_len = 4'd1;
        tick();
        idle();
        #1 chk("vec1_state", state, 0);
        tick();

        // mem_busy for 3 cycles while VEC is at element 1
        id_vec_op = 1; id_vec_len = 4'd4;
        tick();
        idle();
        tick();
        mem_busy = 1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("busy_elem", elem_idx, 1);
            chk("busy_hold", idexe_hold, 1);
            tick();
        end
        mem_busy = 0;
        #1 chk("busy_release_elem", elem_idx, 1);
        tick();
        #1 chk("busy_resume_elem", elem_idx, 2);
        tick(); tick();

        // halt persists until reset
        id_halt = 1;
        tick();
        idle();
        for (int k = 0; k < 10; k++) begin
            #1 chk("halt_halted", halted, 1);
            chk("halt_state", state, 2);
            tick();
        end
        do_reset();
        #1 chk("post_halt_state", state, 0);
        chk("post_halt_halted", halted, 0);

        // stall accounting: 1 load-use + 3 vector holds + 2 memory-wait cycles
        exe_memtoreg = 1; exe_rt_addr = 5'd3; id_rs_addr = 5'd3;
        tick();
        idle();
        id_vec_op = 1; id_vec_len = 4'd4;
        tick();
        idle();
        tick(); tick(); tick();
        tick();
        mem_busy = 1;
        tick(); tick();
        idle();
        tick();
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", stall_cycles, 6);
`else
        chk("perf_stall", stall_cycles, 0);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n            = ($urandom % 60) != 0;
            mem_busy         = ($urandom % 6) == 0;
            exe_branch_taken = ($urandom % 8) == 0;
            exe_memtoreg     = ($urandom % 3) == 0;
            exe_rt_addr      = 5'($urandom % 4);
            id_rs_addr       = 5'($urandom % 4);
            id_rt_addr       = 5'($urandom % 4);
            id_uses_rt       = 1'($urandom % 2);
            id_halt          = ($urandom % 80) == 0;
            id_vec_op        = ($urandom % 5) == 0;
            id_vec_len       = 4'($urandom % 8);
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
